// File: rtl/rs_issue_select_if.sv
// Bundle between the reservation station array / CDB / functional unit and the
// issue select stage. The environment side drives allocation, wakeup and FU ready.
interface rs_issue_select_if #(
  parameter int NUM_RS = 8,
  parameter int PREG_W = 6
);
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic                            branch_mispredict;
  logic [NUM_RS-1:0]               alloc_we;
  logic [NUM_RS-1:0][PREG_W-1:0]   alloc_ps1;
  logic [NUM_RS-1:0][PREG_W-1:0]   alloc_ps2;
  logic [NUM_RS-1:0]               alloc_ps1_rdy;
  logic [NUM_RS-1:0]               alloc_ps2_rdy;
  logic                            cdb_valid;
  logic [PREG_W-1:0]               cdb_ptag;
  logic                            issue_valid;
  logic                            issue_ready;
  logic [IDX_W-1:0]                issue_idx;
  logic [NUM_RS-1:0]               rs_to_free;

  modport master (
    output branch_mispredict, alloc_we, alloc_ps1, alloc_ps2,
           alloc_ps1_rdy, alloc_ps2_rdy, cdb_valid, cdb_ptag, issue_ready,
    input  issue_valid, issue_idx, rs_to_free
  );

  modport slave (
    input  branch_mispredict, alloc_we, alloc_ps1, alloc_ps2,
           alloc_ps1_rdy, alloc_ps2_rdy, cdb_valid, cdb_ptag, issue_ready,
    output issue_valid, issue_idx, rs_to_free
  );
endinterface

// File: rtl/rs_issue_select.sv
// Wakeup/select stage: tracks operand readiness per station via CDB snooping and
// offers the oldest ready station to the FU through a registered valid/ready port.
module rs_issue_select #(
  parameter int NUM_RS = 8,
  parameter int PREG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  rs_issue_select_if.slave   io
);
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0]             valid;
  logic [NUM_RS-1:0]             inflight;
  logic [NUM_RS-1:0]             r1;
  logic [NUM_RS-1:0]             r2;
  logic [NUM_RS-1:0][PREG_W-1:0] ps1;
  logic [NUM_RS-1:0][PREG_W-1:0] ps2;
  logic [NUM_RS-1:0][NUM_RS-1:0] older;

  logic [NUM_RS-1:0] eligible;
  logic [NUM_RS-1:0] pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              cdb_hit;
  logic              handshake;
  logic              load;
  logic [NUM_RS-1:0] free;

  logic              vld_p1;
  logic [IDX_W-1:0]  idx_p1;

  assign cdb_hit   = io.cdb_valid && (io.cdb_ptag != '0);
  assign eligible  = valid & r1 & r2 & ~inflight;
  assign handshake = vld_p1 && io.issue_ready;
  assign load      = !vld_p1 || handshake;

  // Oldest eligible: no other eligible entry claims to be older than it.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      pick[i] = eligible[i];
      for (int j = 0; j < NUM_RS; j++) begin
        if (j != i && eligible[j] && older[j][i]) pick[i] = 1'b0;
      end
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || io.branch_mispredict) begin
      valid    <= '0;
      inflight <= '0;
      older    <= '0;
      vld_p1   <= 1'b0;
      if (rst) begin
        r1     <= '0;
        r2     <= '0;
        idx_p1 <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (handshake && idx_p1 == IDX_W'(i)) begin
          valid[i]    <= 1'b0;
          inflight[i] <= 1'b0;
        end
        if (load && pick[i]) inflight[i] <= 1'b1;
        if (cdb_hit && valid[i] && ps1[i] == io.cdb_ptag) r1[i] <= 1'b1;
        if (cdb_hit && valid[i] && ps2[i] == io.cdb_ptag) r2[i] <= 1'b1;
        if (io.alloc_we[i]) begin
          valid[i]    <= 1'b1;
          inflight[i] <= 1'b0;
          ps1[i]      <= io.alloc_ps1[i];
          ps2[i]      <= io.alloc_ps2[i];
          r1[i]       <= io.alloc_ps1_rdy[i] || (cdb_hit && io.alloc_ps1[i] == io.cdb_ptag);
          r2[i]       <= io.alloc_ps2_rdy[i] || (cdb_hit && io.alloc_ps2[i] == io.cdb_ptag);
        end
        // A new row is older only than higher-index entries allocated alongside it;
        // every already-valid entry becomes older than each new one.
        for (int j = 0; j < NUM_RS; j++) begin
          if (io.alloc_we[i]) older[i][j] <= io.alloc_we[j] && (j > i);
          else if (io.alloc_we[j]) older[i][j] <= valid[i];
        end
      end
      // stage p1: issue register loads when empty or draining this cycle
      if (load) begin
        vld_p1 <= |pick;
        if (|pick) idx_p1 <= pick_idx;
      end
    end
  end

  always_comb begin
    free = '0;
    if (handshake && !io.branch_mispredict) free[idx_p1] = 1'b1;
  end

  assign io.issue_valid = vld_p1;
  assign io.issue_idx   = idx_p1;
  assign io.rs_to_free  = free;
endmodule

// File: doc/rs_issue_select.md
# rs_issue_select

Wakeup/select stage directly downstream of the reservation station array. It mirrors each station's allocation and tracks source-operand readiness by snooping the CDB. Each cycle it picks the oldest station whose operands are both ready and presents it to the functional unit through a registered valid/ready handshake. On a completed handshake it asserts `rs_to_free` so the reservation station array clears that entry's busy bit.

## Interface
Parameters:
- `NUM_RS`, default `NUM_RES_STATIONS` (8): number of stations tracked.
- `PREG_W`, default 6: physical-register tag width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `branch_mispredict`, in, 1: flush all tracked state.
- `alloc_we`, in, `[NUM_RS]`: same vector that drives the reservation station's `rs_we`.
- `alloc_ps1` / `alloc_ps2`, in, `[NUM_RS]` x `PREG_W`: source tags of the entry being written.
- `alloc_ps1_rdy` / `alloc_ps2_rdy`, in, `[NUM_RS]`: source already available at dispatch.
- `cdb_valid`, in, 1: CDB broadcast valid.
- `cdb_ptag`, in, `PREG_W`: tag being broadcast.
- `issue_valid`, out, 1: registered; an entry is offered to the FU.
- `issue_ready`, in, 1: FU accepts this cycle.
- `issue_idx`, out, `$clog2(NUM_RS)`: registered index of the offered station.
- `rs_to_free`, out, `[NUM_RS]`: one-hot. Equals `issue_valid && issue_ready` decoded at `issue_idx`.

## Operation
- Per-entry state: `valid`, `ps1`, `ps2`, `r1`, `r2`, and an `inflight` flag. Ages are kept in an `NUM_RS` x `NUM_RS` age matrix, where `older[i][j]` means i is older than j.
- Allocation (`alloc_we[i]`):
  - Sets `valid[i]`, captures tags, clears `inflight[i]`.
  - `r1 = alloc_ps1_rdy[i] | (cdb_valid && cdb_ptag==alloc_ps1[i] && cdb_ptag!=0)`; `r2` likewise.
  - Row i becomes older-than nothing currently valid: `older[j][i]=1` for every valid j.
  - Among simultaneous allocations, the lower index is older.
- Wakeup: when `cdb_valid && cdb_ptag!=0`, every valid entry with a matching ps1/ps2 sets `r1`/`r2`. Tag 0 never broadcasts.
- Eligible entry: `valid & r1 & r2 & ~inflight`.
- Select: the oldest eligible entry, i.e. no other eligible entry is older than it.
- Issue register:
  - If empty, or if it completes a handshake this cycle, it loads the selected entry (if any) and sets that entry's `inflight`.
  - If nothing is eligible, `issue_valid` drops.
- Handshake completing on entry k: `rs_to_free[k]=1` for exactly that cycle, and `valid[k]`/`inflight[k]` clear at the edge.
- While `issue_valid && !issue_ready`, `issue_idx` is held stable. An older entry arriving later does not displace it.
- `branch_mispredict`:
  - Clears all `valid`/`inflight`/age state and `issue_valid` at the edge, and forces `rs_to_free` to 0 that cycle.
  - Allocations in the same cycle are dropped, matching the reservation station array.
- Illegal conditions, which the bench flags with assertions:
  - `alloc_we[i]` on a valid entry.
  - `issue_ready` asserted without `issue_valid`.

## Timing
- Reset values:
  - Outputs: `issue_valid=0`, `issue_idx=0`, `rs_to_free=0`.
  - Internal: all `valid`, `inflight`, `r1`, `r2`, and age bits 0.
- Allocation with both sources ready, alloc in cycle c:
  - Entry becomes eligible in c+1.
  - `issue_valid` is high in c+2.
  - Minimum latency from alloc to issue is 2.
- CDB wakeup in cycle w: the entry is eligible in w+1 and `issue_valid` is high in w+2. There is no same-cycle wakeup-select.
- Back-to-back issue: a handshake in cycle k loads the next pick at the same edge, so `issue_valid` stays high in k+1. One issue per cycle is sustained.
- `rs_to_free` is combinational from registered `issue_valid`/`issue_idx` and the `issue_ready` input, and holds for one cycle per handshake.
- `rst` and `branch_mispredict` both take effect at the next edge and have priority over every other event.

## Test plan
- Alloc entry 2 with both ready in cycle 0, `issue_ready=1` -> `issue_valid=1`, `issue_idx=2` in cycle 2; `rs_to_free=8'b0000_0100` in cycle 2 only.
- Alloc entry 5 in cycle 0 and entry 1 in cycle 1, all ready -> issues idx 5 in cycle 2, then idx 1 in cycle 3. Also alloc entries 0 and 6 in the same cycle -> idx 0 issues first.
- Alloc entry 3 with `ps1=7` not ready and ps2 ready; `cdb_valid`, `cdb_ptag=7` in cycle 4 -> idx 3 offered in cycle 6. A separate alloc with `ps1=7` in the same cycle as the tag-7 broadcast -> issues 2 cycles later.
- Entry 4 offered with `issue_ready=0` for cycles 2-4; older-ready entries allocated meanwhile -> `issue_idx` stays 4 and `rs_to_free=0` until ready rises in cycle 5. `rs_to_free[4]=1` in cycle 5.
- `branch_mispredict` in cycle 3 while entry 1 is offered and entries 2 and 6 are waiting -> `issue_valid=0` from cycle 4, `rs_to_free=0` in cycle 3, and nothing issues afterwards despite CDB wakeups.
- `rst` asserted mid-stream with 4 entries valid -> all outputs 0 the next cycle. A fresh alloc afterwards issues with the 2-cycle latency.
